// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes, FSM state encoding and flag bit positions shared by the multiply/divide unit.
package muldiv_pkg;
    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_UMULL = 3'd1;
    localparam logic [2:0] OP_SMULL = 3'd2;
    localparam logic [2:0] OP_UDIV  = 3'd3;
    localparam logic [2:0] OP_SDIV  = 3'd4;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement of a WIDTH-bit value.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? (~x) + WIDTH'(1) : x;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide with start/done handshake.
// Signed SMULL/SDIV are built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t             state;
    logic [2:0]         op_r, op_eff;
    logic               neg_q, neg_r, ovf, sa, sb, ovf_in;
    logic               is_div, is_div_in, dbz_in, legal, fix_long;
    logic [WIDTH-1:0]   m, mag_a, mag_b, q_fix, r_fix, fix_lo, fix_hi;
    logic [2*WIDTH-1:0] acc, acc_nx, p_fix;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     psum, rsh, diff;
    logic [3:0]         fix_flags;
`ifdef MULDIV_SIGNED_EN
    assign op_eff = op;
    assign sa     = (op == OP_SMULL || op == OP_SDIV) && a[WIDTH-1];
    assign sb     = (op == OP_SMULL || op == OP_SDIV) && b[WIDTH-1];
    assign ovf_in = op == OP_SDIV && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
`else
    assign op_eff = op == OP_SMULL ? OP_UMULL : op == OP_SDIV ? OP_UDIV : op;
    assign sa     = 1'b0;
    assign sb     = 1'b0;
    assign ovf_in = 1'b0;
`endif
    assign legal     = op_eff <= OP_SDIV;
    assign is_div_in = op_eff == OP_UDIV || op_eff == OP_SDIV;
    assign dbz_in    = is_div_in && ~|b;
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(sa), .x(a), .y(mag_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(sb), .x(b), .y(mag_b));
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign is_div = op_r == OP_UDIV || op_r == OP_SDIV;
    assign psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    assign rsh    = acc[2*WIDTH-1:WIDTH-1];
    assign diff   = rsh - {1'b0, m};
    assign acc_nx = !is_div ? {psum, acc[WIDTH-1:1]} :
                    diff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                    {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_p (.neg(neg_q), .x(acc), .y(p_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_q (.neg(neg_q), .x(acc[WIDTH-1:0]), .y(q_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_r (.neg(neg_r), .x(acc[2*WIDTH-1:WIDTH]), .y(r_fix));
    assign fix_long  = op_r == OP_UMULL || op_r == OP_SMULL;
    assign fix_lo    = is_div ? q_fix : p_fix[WIDTH-1:0];
    assign fix_hi    = is_div ? r_fix : op_r == OP_MUL ? '0 : p_fix[2*WIDTH-1:WIDTH];
    assign fix_flags = {fix_long ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1],
                        fix_long ? ~|{fix_hi, fix_lo} : ~|fix_lo, 1'b0, ovf};
    assign ready = state == S_IDLE;
    assign busy  = state != S_IDLE;
    assign done  = state == S_DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_r        <= OP_MUL;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf         <= 1'b0;
            m           <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            flags       <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op_r        <= op_eff;
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            ovf         <= ovf_in;
            m           <= is_div_in ? mag_b : mag_a;
            acc         <= {{WIDTH{1'b0}}, is_div_in ? mag_a : mag_b};
            cnt         <= CW'(WIDTH-1);
            div_by_zero <= dbz_in;
            // divide-by-zero and illegal ops bypass the datapath entirely
            if (!legal || dbz_in) begin
                state     <= S_DONE;
                result_lo <= legal ? '1 : '0;
                result_hi <= legal ? a : '0;
                flags     <= legal ? 4'b1000 : 4'b0000;
            end else begin
                state <= S_CALC;
            end
        end else if (state == S_CALC) begin
            acc   <= acc_nx;
            cnt   <= cnt - CW'(1);
            state <= ~|cnt ? S_FIX : S_CALC;
        end else if (state == S_FIX) begin
            result_lo <= fix_lo;
            result_hi <= fix_hi;
            flags     <= fix_flags;
            state     <= S_DONE;
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by an independent done monitor.
module tb_muldiv_unit;
    logic        clk, reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready, busy, done, div_by_zero;
    logic [31:0] result_lo, result_hi;
    logic [3:0]  flags;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
        logic        dbz;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .flags(flags), .div_by_zero(div_by_zero)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_lo", {32'd0, result_lo}, {32'd0, e.lo});
                chk("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
                chk("flags", {60'd0, flags}, {60'd0, e.fl});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end
    task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] elo, input logic [31:0] ehi, input logic [3:0] efl,
                         input logic edbz, input int lat, input bit push, output int acc_cyc);
        int n = 0;
        exp_t e;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
        start = 1'b1;
        op = o;
        a = xa;
        b = xb;
        if (push) begin
            e.lo = elo;
            e.hi = ehi;
            e.fl = efl;
            e.dbz = edbz;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask
    initial begin
        int t0, t1, n;
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_outputs", {result_hi, result_lo}, 64'd0);
        chk("rst_flags_dbz", {59'd0, flags, div_by_zero}, 64'd0);
        reset = 1'b0;
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0, 34, 1, t0);
`ifdef MULDIV_SIGNED_EN
        issue(3'd2, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 1'b0, 34, 1, t0);
`else
        issue(3'd2, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'h00000006, 4'b0000, 1'b0, 34, 1, t0);
`endif
        issue(3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 1'b0, 34, 1, t0);
`ifdef MULDIV_SIGNED_EN
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 1'b0, 34, 1, t0);
`else
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h00000001, 4'b0000, 1'b0, 34, 1, t0);
`endif
        issue(3'd3, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 4'b1000, 1'b1, 1, 1, t0);
`ifdef MULDIV_SIGNED_EN
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 4'b1001, 1'b0, 34, 1, t0);
`else
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 4'b0100, 1'b0, 34, 1, t0);
`endif
        // MUL with an ignored start mid-flight, then back-to-back issue
        issue(3'd0, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 4'b0100, 1'b0, 34, 1, t0);
        repeat (4) @(negedge clk);
        chk("busy_mid_op", {62'd0, busy, ready}, 64'd2);
        start = 1'b1;
        op = 3'd3;
        a = 32'd1;
        b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        issue(3'd0, 32'd6, 32'd7, 32'd42, 32'd0, 4'b0000, 1'b0, 34, 1, t1);
        chk("reissue_cycle", 64'(t1 - t0), 64'd35);
        issue(3'd7, 32'd3, 32'd4, 32'd0, 32'd0, 4'b0000, 1'b0, 1, 1, t0);
        issue(3'd4, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7, 4'b1000, 1'b1, 1, 1, t0);
        // reset in the middle of a divide: no done, outputs cleared
        issue(3'd3, 32'd1000, 32'd3, 32'd0, 32'd0, 4'b0000, 1'b0, 34, 0, t0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", {62'd0, ready, busy}, 64'd2);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_outputs", {result_hi, result_lo}, 64'd0);
        chk("abort_flags_dbz", {59'd0, flags, div_by_zero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op = 3'd3;
        a = 32'd9;
        b = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_idle", {62'd0, ready, busy}, 64'd2);
        repeat (40) @(negedge clk);
        chk("rst_start_dropped", {63'd0, div_by_zero}, 64'd0);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
